// File: rtl/mix_columns_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : mix_columns_seq_if
// Description : Input/output handshake bundle for the sequential MixColumns
//               block. The slave modport is the block side, the master modport
//               is the producer/consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  modport slave (
    input  in_valid,
    input  in_state,
    input  in_bypass,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_state
  );

  modport master (
    output in_valid,
    output in_state,
    output in_bypass,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_state
  );
endinterface
`default_nettype wire

// File: rtl/mix_columns_seq.sv
`default_nettype none
// ============================================================================
// Module      : mix_columns_seq
// Description : AES MixColumns over a 128-bit state using a single 32-bit
//               column mixer, one column per cycle (column 0 first). A bypass
//               flag captured with the state passes it through unchanged for
//               the final round.
// Revision    : 1.0 - initial release
// ============================================================================
module mix_columns_seq (
  input  wire logic          clk,
  input  wire logic          rst,
  mix_columns_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       r_fsm;
  state_t       w_fsm_nxt;
  logic [127:0] r_in;
  logic [127:0] r_result;
  logic         r_bypass;
  logic [1:0]   r_col;
  logic         w_in_ready;
  logic         w_out_valid;
  logic         w_accept;
  logic [6:0]   w_col_base;
  logic [31:0]  w_col_in;
  logic [31:0]  w_col_out;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // One column of the forward MixColumns matrix; row 0 is the top byte.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3),
            (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_col_base = {r_col, 5'b00000};
  assign w_col_in   = r_in[w_col_base +: 32];
  assign w_col_out  = mix_column(w_col_in);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm <= IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_fsm)
      IDLE: begin
        w_in_ready = !rst;
        if (bus.in_valid && !rst) begin
          w_fsm_nxt = bus.in_bypass ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (r_col == 2'd3) begin
          w_fsm_nxt = DONE;
        end
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_fsm_nxt = IDLE;
        end
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

  // Capture the input on accept, then fill the result one column per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in     <= 128'h0;
      r_bypass <= 1'b0;
      r_col    <= 2'd0;
      r_result <= 128'h0;
    end else begin
      if (r_fsm == IDLE && w_accept) begin
        r_in     <= bus.in_state;
        r_bypass <= bus.in_bypass;
        r_col    <= 2'd0;
        if (bus.in_bypass) begin
          r_result <= bus.in_state;
        end
      end else if (r_fsm == BUSY && !r_bypass) begin
        r_result[w_col_base +: 32] <= w_col_out;
        r_col                      <= r_col + 2'd1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_state = r_result;

endmodule
`default_nettype wire

// File: tb/tb_mix_columns_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mix_columns_seq
// Description : Scoreboard bench for mix_columns_seq. Expected results are
//               queued at accept time and popped by an output monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mix_columns_seq;

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
    logic         byp;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   rand_ready = 1'b0;
  sb_t  q[$];
  sb_t  mon_e;

  localparam logic [127:0] C_V1_IN  = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] C_V1_OUT = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
  localparam logic [127:0] C_V2_IN  = 128'hc6c6c6c6_d4d4d4d5_00000000_ffffffff;
  localparam logic [127:0] C_V2_OUT = 128'hc6c6c6c6_d5d5d7d6_00000000_ffffffff;

  mix_columns_seq_if bus ();

  mix_columns_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Generic GF(2^8) product by shift-and-add.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Circulant matrix product on every column; row r byte at bits c*32+(3-r)*8.
  function automatic logic [127:0] mat_mix(input logic [127:0] s, input logic [31:0] coef);
    logic [127:0] o = '0;
    logic [7:0]   base [4];
    logic [7:0]   acc;
    base[0] = coef[31:24]; base[1] = coef[23:16];
    base[2] = coef[15:8];  base[3] = coef[7:0];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc ^= gmul(base[(k - r + 4) % 4], s[c*32 + (3-k)*8 +: 8]);
        o[c*32 + (3-r)*8 +: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] fwd(input logic [127:0] s);
    return mat_mix(s, 32'h02030101);
  endfunction

  function automatic logic [127:0] inv(input logic [127:0] s);
    return mat_mix(s, 32'h0e0b0d09);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Offer one state and hold it until accepted; returns the accept cycle.
  task automatic send(input logic [127:0] d, input logic b, input logic [127:0] exp,
                      output int acc_cyc);
    bit seen = 1'b0;
    sb_t e;
    bus.in_valid  = 1'b1;
    bus.in_state  = d;
    bus.in_bypass = b;
    acc_cyc = -1;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (bus.in_ready) seen = 1'b1;
    end
    if (!seen) begin
      errors++;
      $display("FAIL accept_timeout actual=no_accept expected=accept");
      bus.in_valid = 1'b0;
    end else begin
      e.din = d; e.exp = exp; e.byp = b;
      q.push_back(e);
      @(posedge clk);
      #1;
      acc_cyc       = cyc;
      bus.in_valid  = 1'b0;
      bus.in_state  = rnd128();
      bus.in_bypass = $urandom_range(0, 1) == 1;
    end
  endtask

  // Edges after the accept edge until out_valid is seen.
  task automatic measure_latency(input string name, input int exp_k);
    int k = 0;
    while (!bus.out_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, k, exp_k);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge clk);
    check("drain", q.size(), 0);
  endtask

  // Output monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_output actual=%h expected=none", bus.out_state);
      end else begin
        mon_e = q.pop_front();
        check("result", bus.out_state, mon_e.exp);
        if (!mon_e.byp) check("inverse", inv(bus.out_state), mon_e.din);
      end
    end
  end

  // Random sink backpressure during the random phase.
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      bus.out_ready = $urandom_range(0, 3) != 0;
    end
  end

  initial begin
    int a0, a1, rel;
    logic [127:0] d, e;
    logic b;
    bus.in_valid  = 1'b0;
    bus.in_state  = '0;
    bus.in_bypass = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("ready_in_reset", bus.in_ready, 0);
    check("valid_in_reset", bus.out_valid, 0);
    check("state_in_reset", bus.out_state, 0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", bus.in_ready, 1);

    // Known vectors with latency.
    bus.out_ready = 1'b1;
    send(C_V1_IN, 1'b0, C_V1_OUT, a0);
    measure_latency("latency_v1", 4);
    check("v1_out", bus.out_state, C_V1_OUT);
    @(posedge clk);
    #1;
    check("idle_ready", bus.in_ready, 1);
    check("idle_valid", bus.out_valid, 0);

    send(C_V2_IN, 1'b0, C_V2_OUT, a0);
    measure_latency("latency_v2", 4);
    wait_drain();

    // Bypass: result is already valid right after the accept edge.
    send(C_V1_IN, 1'b1, C_V1_IN, a0);
    measure_latency("latency_bypass", 0);
    check("bypass_out", bus.out_state, C_V1_IN);
    wait_drain();

    // Back-to-back accepts with the sink always ready.
    d = rnd128();
    send(d, 1'b0, fwd(d), a0);
    d = rnd128();
    send(d, 1'b0, fwd(d), a1);
    check("accept_spacing", a1 - a0, 6);
    wait_drain();

    // Backpressure in DONE.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    d = rnd128();
    e = fwd(d);
    send(d, 1'b0, e, a0);
    measure_latency("latency_bp", 4);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.in_state = rnd128();
      @(posedge clk);
      #1;
      check("bp_valid", bus.out_valid, 1);
      check("bp_state", bus.out_state, e);
      check("bp_ready", bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", bus.out_valid, 0);
    check("bp_release_ready", bus.in_ready, 1);
    check("bp_single_pop", q.size(), 0);

    // Reset while column 2 is being mixed.
    send(C_V2_IN, 1'b0, C_V2_OUT, a0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    check("rst_mid_valid", bus.out_valid, 0);
    check("rst_mid_state", bus.out_state, 0);
    check("rst_mid_ready", bus.in_ready, 0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    rel = cyc;
    send(C_V1_IN, 1'b0, C_V1_OUT, a0);
    check("first_accept_after_reset", a0 - rel, 1);
    measure_latency("latency_after_reset", 4);
    check("after_reset_out", bus.out_state, C_V1_OUT);
    wait_drain();

    // Random traffic with random source gaps and sink backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      d = rnd128();
      b = $urandom_range(0, 7) == 0;
      send(d, b, b ? d : fwd(d), a0);
    end
    wait_drain();
    rand_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
